// File: rtl/udp_payload_parser.sv
// udp_payload_parser: packs the UDP payload byte stream into 11-byte market-data records.
// Optional feature macro: PARSER_ERR_CNT_EN adds a saturating runt counter on err_count.
`default_nettype none

module udp_payload_parser #(
  parameter int BYTE_LANE = 0,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [7:0]           rec_type,
  output logic [15:0]          rec_sym,
  output logic [31:0]          rec_price,
  output logic [31:0]          rec_qty,
  output logic                 rec_last,
  output logic                 err_runt
`ifdef PARSER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam logic [3:0] LAST_IDX = 4'd10;

  logic [3:0]  idx;
  logic [79:0] shreg;
  logic [7:0]  byte_in;
  logic        accept;
  logic        load;
  logic        runt;
  logic        unused_bits;

  assign byte_in       = s_axis_tdata[BYTE_LANE*8 +: 8];
  assign s_axis_tready = !(rec_valid && !rec_ready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign load          = accept && (idx == LAST_IDX);
  assign runt          = accept && s_axis_tlast && (idx != LAST_IDX);
  assign unused_bits   = ^{s_axis_tdata, (ERR_CNT_W > 0)};

  // First byte of a record ends up in the top of shreg, so fields slice out big-endian.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      shreg <= '0;
    end else if (accept) begin
      if (load || s_axis_tlast) begin
        idx <= '0;
      end else begin
        idx   <= idx + 4'd1;
        shreg <= {shreg[71:0], byte_in};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_valid <= 1'b0;
      rec_type  <= '0;
      rec_sym   <= '0;
      rec_price <= '0;
      rec_qty   <= '0;
      rec_last  <= 1'b0;
      err_runt  <= 1'b0;
    end else begin
      err_runt <= runt;
      if (load) begin
        rec_valid <= 1'b1;
        rec_type  <= shreg[79:72];
        rec_sym   <= shreg[71:56];
        rec_price <= shreg[55:24];
        rec_qty   <= {shreg[23:0], byte_in};
        rec_last  <= s_axis_tlast;
      end else if (rec_ready) begin
        rec_valid <= 1'b0;
      end
    end
  end

`ifdef PARSER_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_runt && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_udp_payload_parser.sv
// tb_udp_payload_parser: directed and randomized packets checked against a record-queue model.
`default_nettype none

module tb_udp_payload_parser;

  localparam int LANE = 2;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [7:0]  t;
    logic [15:0] s;
    logic [31:0] p;
    logic [31:0] q;
    logic        l;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        rec_valid;
  logic        rec_ready;
  logic [7:0]  rec_type;
  logic [15:0] rec_sym;
  logic [31:0] rec_price;
  logic [31:0] rec_qty;
  logic        rec_last;
  logic        err_runt;
`ifdef PARSER_ERR_CNT_EN
  logic [CW-1:0] err_count;
`endif

  always #5 clk = ~clk;

  udp_payload_parser #(.BYTE_LANE(LANE), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_type(rec_type), .rec_sym(rec_sym), .rec_price(rec_price),
    .rec_qty(rec_qty), .rec_last(rec_last), .err_runt(err_runt)
`ifdef PARSER_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  int          total = 0;
  int          bad = 0;
  rec_t        exp_q[$];
  logic [7:0]  pkt[$];
  int          exp_runts = 0;
  int          seen_runts = 0;
  int          exp_cnt = 0;
  logic        rand_rdy = 1'b0;
  rec_t        mon_got;
  rec_t        mon_exp;
  rec_t        exp_a;
  int          cyc;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Reference: a packet of n bytes carries n/11 whole records; any remainder is one runt.
  function automatic void model_packet();
    int n = pkt.size();
    int nrec = n / 11;
    for (int r = 0; r < nrec; r++) begin
      int b = r * 11;
      rec_t e;
      e.t = pkt[b];
      e.s = {pkt[b+1], pkt[b+2]};
      e.p = {pkt[b+3], pkt[b+4], pkt[b+5], pkt[b+6]};
      e.q = {pkt[b+7], pkt[b+8], pkt[b+9], pkt[b+10]};
      e.l = (r == nrec - 1) && (n % 11 == 0);
      exp_q.push_back(e);
    end
    if (n % 11 != 0) begin
      exp_runts++;
      exp_cnt++;
    end
  endfunction

  function automatic void rand_packet(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
  endfunction

  task automatic send_beat(input logic [7:0] b, input logic l);
    logic [31:0] d;
    int k;
    d = $urandom;
    d[LANE*8 +: 8] = b;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    k = 0;
    @(negedge clk);
    while (!s_axis_tready && k < 300) begin
      k++;
      @(negedge clk);
    end
    if (k >= 300) chk("beat_timeout", k, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(output int cycles);
    time t0;
    @(posedge clk);
    #1;
    t0 = $time;
    for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], i == pkt.size() - 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cycles = int'(($time - t0) / 10);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      k++;
      @(posedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_runts(input string tag);
    chk(tag, seen_runts, exp_runts);
`ifdef PARSER_ERR_CNT_EN
    chk({tag, "_cnt"}, err_count, (exp_cnt > CMAX) ? CMAX : exp_cnt);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n && err_runt) seen_runts++;
    if (rst_n && rec_valid && rec_ready) begin
      mon_got = {rec_type, rec_sym, rec_price, rec_qty, rec_last};
      chk("rec_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        chk("rec_fields", mon_got, mon_exp);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rec_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst_n = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    rec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rec_valid, 0);
    chk("rst_fields", {rec_type, rec_sym, rec_price, rec_qty, rec_last}, 0);
    chk("rst_runt", err_runt, 0);
    chk("rst_tready", s_axis_tready, 1);
`ifdef PARSER_ERR_CNT_EN
    chk("rst_cnt", err_count, 0);
`endif
    rst_n = 1'b1;

    // Known 11-byte record
    pkt = '{8'h41, 8'h00, 8'h07, 8'h00, 8'h01, 8'h86, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h64};
    model_packet();
    send_packet(cyc);
    chk("t1_cycles", cyc, 11);
    chk("t1_latency", rec_valid, 1);
    chk("t1_fields", {rec_type, rec_sym, rec_price, rec_qty, rec_last},
        {8'h41, 16'h0007, 32'h000186A0, 32'h00000064, 1'b1});
    drain();

    // Two back-to-back records at full rate
    rand_packet(22);
    model_packet();
    send_packet(cyc);
    chk("t2_no_stall", cyc, 22);
    drain();
    chk_runts("t2_runts");

    // Two records then a 3-byte runt
    rand_packet(25);
    model_packet();
    send_packet(cyc);
    chk("t3_runt_pulse", err_runt, 1);
    @(posedge clk);
    #1;
    chk("t3_runt_clear", err_runt, 0);
    drain();
    chk_runts("t3_runts");

    // Lone tlast beat is a 1-byte runt
    rand_packet(1);
    model_packet();
    send_packet(cyc);
    drain();
    chk_runts("t4_runts");

    // Output backpressure for 5 cycles while the next packet waits
    rec_ready = 1'b0;
    rand_packet(11);
    model_packet();
    exp_a = exp_q[exp_q.size() - 1];
    send_packet(cyc);
    chk("bp_valid", rec_valid, 1);
    rand_packet(11);
    model_packet();
    fork
      send_packet(cyc);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_tready", s_axis_tready, 0);
          chk("bp_hold", {rec_type, rec_sym, rec_price, rec_qty, rec_last}, exp_a);
        end
        @(posedge clk);
        #1;
        rec_ready = 1'b1;
      end
    join
    chk("bp_resume_cycles", cyc, 15);
    drain();

    // Asynchronous reset in the middle of a record
    for (int i = 0; i < 5; i++) send_beat(8'($urandom), 1'b0);
    s_axis_tvalid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rec_valid, 0);
    chk("mid_rst_fields", {rec_type, rec_sym, rec_price, rec_qty, rec_last}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    pkt = '{8'h42, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    model_packet();
    send_packet(cyc);
    chk("post_rst_fields", {rec_type, rec_sym, rec_price, rec_qty, rec_last},
        {8'h42, 16'h1234, 32'hDEADBEEF, 32'h01020304, 1'b1});
    drain();
    chk_runts("post_rst_runts");

    // Random packet lengths with random output backpressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      rand_packet($urandom_range(1, 40));
      model_packet();
      send_packet(cyc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    rec_ready = 1'b1;
    drain();
    chk_runts("rand_runts");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/udp_payload_parser.md
Name: udp_payload_parser

Overview:
Consumes the filtered UDP payload stream that leaves the UDP port filter (one payload byte per beat, after the FIFO) and assembles fixed 11-byte market-data records into a parallel record bus. A packet may carry any number of back-to-back records. Trailing partial records are discarded and flagged. Sits between the payload FIFO and the order/book logic.

Parameters:
BYTE_LANE, 0, index of the s_axis_tdata byte lane carrying the payload byte (0..3); other lanes are ignored.
ERR_CNT_W, 16, width of the runt-record error counter (used only when PARSER_ERR_CNT_EN is defined).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  32  payload byte in lane BYTE_LANE
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  last payload byte of the UDP packet
s_axis_tready  out  1  parser can accept a beat
rec_valid  out  1  record output valid
rec_ready  in  1  downstream accepts record
rec_type  out  8  record byte 0
rec_sym  out  16  record bytes 1-2, big-endian
rec_price  out  32  record bytes 3-6, big-endian
rec_qty  out  32  record bytes 7-10, big-endian
rec_last  out  1  record ended exactly on s_axis_tlast
err_runt  out  1  one-cycle pulse: partial record dropped at tlast
err_count  out  ERR_CNT_W  saturating runt count (only with PARSER_ERR_CNT_EN)

Behaviour:
- Clock clk; reset rst_n is asynchronous and active-low. Reset: rec_valid=0, rec_* fields=0, rec_last=0, err_runt=0, err_count=0, byte index=0, shift register=0.
- Byte index idx counts 0..10 within the current record. A beat is accepted when s_axis_tvalid && s_axis_tready.
- s_axis_tready = !(rec_valid && !rec_ready). Combinational, no bubble: the parser accepts input whenever the output register is empty or being drained in the same cycle.
- Accepted beat with idx<10 and !tlast: shift the byte into the assembly register, idx <= idx+1.
- Accepted beat with idx==10: load all rec_* fields from the assembly register plus the current byte. rec_valid <= 1 on the next edge (1-cycle latency from the last-byte accept). rec_last <= s_axis_tlast. idx <= 0.
- Accepted beat with tlast and idx<10: discard the partial record (no rec_valid), pulse err_runt for exactly one cycle, idx <= 0. The next beat starts a new record.
- rec_valid clears on a rec_valid && rec_ready cycle unless a new record loads on the same edge; in that case rec_valid stays 1 with the new fields (back-to-back, full throughput of 1 byte/cycle).
- While rec_valid && !rec_ready, rec_* fields are held stable and no input is accepted.
- Byte order: the first byte received is the MSB of each multi-byte field.
- idx never exceeds 10. An 11-byte packet yields exactly one record with rec_last=1.
- Zero-length packets cannot occur (every beat carries a byte). A lone tlast beat with idx==0 is a 1-byte runt and raises err_runt.

Optional Feature:
PARSER_ERR_CNT_EN: when defined, adds the err_count port. It increments on every err_runt pulse, saturates at all-ones, and resets to 0. When undefined, neither the port nor the counter exists; err_runt is still present.

Test Plan:
- One 11-byte packet, bytes 0x41,0x00,0x07,0x00,0x01,0x86,0xA0,0x00,0x00,0x00,0x64 with tlast on the last byte -> one record: rec_type=0x41, rec_sym=0x0007, rec_price=0x000186A0, rec_qty=0x00000064, rec_last=1; rec_valid asserts 1 cycle after the last accept.
- 22-byte packet, continuous valid, rec_ready=1 -> two records on consecutive 11-cycle boundaries; first has rec_last=0, second has rec_last=1; s_axis_tready never drops.
- 25-byte packet -> two records (second rec_last=0), then err_runt pulses once at the tlast beat; err_count=1 with PARSER_ERR_CNT_EN.
- rec_ready held 0 for 5 cycles after a record completes while input is valid -> s_axis_tready=0 and rec_* fields stable for those 5 cycles; input resumes on the cycle rec_ready=1 with no byte lost or duplicated.
- rst_n asserted after byte 5 of a record, then a fresh 11-byte packet -> outputs go to reset values immediately; only the fresh packet's record appears, with correct fields.
- BYTE_LANE=2, payload placed in tdata[23:16] with garbage in the other lanes -> records decoded from lane 2 only.
